// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle datapath memory stage.
package mips_pkg;

  typedef enum logic [1:0] {
    MW_READ = 2'b00,
    MW_WORD = 2'b01,
    MW_BYTE = 2'b10
  } memwr_t;

  typedef enum logic [1:0] {
    LT_WORD = 2'b00,
    LT_LBU  = 2'b01,
    LT_LB   = 2'b10
  } ltype_t;

  typedef enum logic [1:0] {
    MAU_IDLE = 2'b00,
    MAU_WAIT = 2'b01,
    MAU_DONE = 2'b10
  } mau_state_t;

  // Widen a byte to a word, replicating bit 7 when sign is set.
  function automatic logic [31:0] byte_ext(input logic [7:0] b, input logic sign);
    return {{24{sign & b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Byte-lane steering: byte enables, store data replication, load extension
// and detection of misaligned or illegal access encodings.
module mem_lane_steer
  import mips_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic        ifetch,
  input  logic [1:0]  memwr,
  input  logic [1:0]  ltype,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic        bad
);

  logic [7:0] sel_byte;

  // Select the addressed byte of the read word (little-endian).
  always_comb begin
    sel_byte = mem_rdata[7:0];
    case (lane)
      2'd0:    sel_byte = mem_rdata[7:0];
      2'd1:    sel_byte = mem_rdata[15:8];
      2'd2:    sel_byte = mem_rdata[23:16];
      default: sel_byte = mem_rdata[31:24];
    endcase
  end

  // Decode access type into lane controls; stores take precedence over ltype.
  always_comb begin
    be        = 4'b1111;
    wdata     = 32'h0;
    rdata_ext = mem_rdata;
    bad       = 1'b0;
    case (memwr)
      MW_WORD: begin
        wdata = cpu_wdata;
        bad   = ifetch | (lane != 2'd0);
      end
      MW_BYTE: begin
        be    = 4'b0001 << lane;
        wdata = {4{cpu_wdata[7:0]}};
        bad   = ifetch;
      end
      MW_READ: begin
        if (ifetch) begin
          bad = (lane != 2'd0);
        end else begin
          case (ltype)
            LT_WORD: bad       = (lane != 2'd0);
            LT_LB:   rdata_ext = byte_ext(sel_byte, 1'b1);
            LT_LBU:  rdata_ext = byte_ext(sel_byte, 1'b0);
            default: bad       = 1'b1;
          endcase
        end
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: turns per-state memory controls from the main FSM
// into a req/ack bus transaction, stalls the FSM until it completes, and owns
// the instruction and memory data registers.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  MAU_IDLE | no access in flight; a cpu_req is latched here
//  MAU_WAIT | mem_req held with stable bus fields until ack or timeout
//  MAU_DONE | one cycle with stall released; err reports a flagged fault
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_ifetch,
  input  logic [1:0]        cpu_memwr,
  input  logic [1:0]        cpu_ltype,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              stall,
  output logic [31:0]       instr,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  mau_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_flag_q, err_flag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ifetch_q, ifetch_d;
  logic [1:0]        memwr_q, memwr_d;
  logic [1:0]        ltype_q, ltype_d;
  logic [1:0]        lane_q, lane_d;

  logic              in_idle;
  logic [1:0]        s_lane, s_memwr, s_ltype;
  logic              s_ifetch;
  logic [3:0]        s_be;
  logic [31:0]       s_wdata, s_rdata_ext;
  logic              s_bad;
  logic              ack_seen, timeout;

  assign in_idle  = (state_q == MAU_IDLE);
  // In IDLE the steering decodes the live request; afterwards it uses the latched one.
  assign s_lane   = in_idle ? cpu_addr[1:0] : lane_q;
  assign s_memwr  = in_idle ? cpu_memwr     : memwr_q;
  assign s_ltype  = in_idle ? cpu_ltype     : ltype_q;
  assign s_ifetch = in_idle ? cpu_ifetch    : ifetch_q;

  mem_lane_steer u_steer (
    .lane      (s_lane),
    .ifetch    (s_ifetch),
    .memwr     (s_memwr),
    .ltype     (s_ltype),
    .cpu_wdata (cpu_wdata),
    .mem_rdata (mem_rdata),
    .be        (s_be),
    .wdata     (s_wdata),
    .rdata_ext (s_rdata_ext),
    .bad       (s_bad)
  );

  assign ack_seen = mem_req_q & mem_ack;
  assign timeout  = (cnt_q == CNT_W'(MAX_WAIT - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= MAU_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; ack wins over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MAU_IDLE: if (cpu_req) state_d = s_bad ? MAU_DONE : MAU_WAIT;
      MAU_WAIT: if (ack_seen || timeout) state_d = MAU_DONE;
      MAU_DONE: state_d = MAU_IDLE;
      default:  state_d = MAU_IDLE;
    endcase
  end

  // FSM outputs: stall is combinational so the main FSM never leaves early.
  always_comb begin
    stall = (in_idle & cpu_req) | (state_q == MAU_WAIT);
    err   = (state_q == MAU_DONE) & err_flag_q;
  end

  // Datapath next values: request latch, bus fields, counter, IR and MDR.
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    instr_d     = instr_q;
    rdata_d     = rdata_q;
    err_flag_d  = err_flag_q;
    cnt_d       = cnt_q;
    ifetch_d    = ifetch_q;
    memwr_d     = memwr_q;
    ltype_d     = ltype_q;
    lane_d      = lane_q;
    case (state_q)
      MAU_IDLE: begin
        if (cpu_req) begin
          ifetch_d   = cpu_ifetch;
          memwr_d    = cpu_memwr;
          ltype_d    = cpu_ltype;
          lane_d     = cpu_addr[1:0];
          cnt_d      = '0;
          err_flag_d = s_bad;
          if (!s_bad) begin
            mem_req_d   = 1'b1;
            mem_we_d    = (cpu_memwr != MW_READ);
            mem_be_d    = s_be;
            mem_addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = s_wdata;
          end
        end
      end
      MAU_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ack_seen) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = 4'b0000;
          if (ifetch_q)                instr_d = mem_rdata;
          else if (memwr_q == MW_READ) rdata_d = s_rdata_ext;
        end else if (timeout) begin
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_be_d   = 4'b0000;
          err_flag_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      instr_q     <= 32'h0;
      rdata_q     <= 32'h0;
      err_flag_q  <= 1'b0;
      cnt_q       <= '0;
      ifetch_q    <= 1'b0;
      memwr_q     <= 2'b00;
      ltype_q     <= 2'b00;
      lane_q      <= 2'b00;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      instr_q     <= instr_d;
      rdata_q     <= rdata_d;
      err_flag_q  <= err_flag_d;
      cnt_q       <= cnt_d;
      ifetch_q    <= ifetch_d;
      memwr_q     <= memwr_d;
      ltype_q     <= ltype_d;
      lane_q      <= lane_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign instr     = instr_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected bus cycles
// and completions; a negedge monitor pops and compares them.
module tb_mem_access_unit;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_ifetch = 1'b0;
  logic [1:0]  cpu_memwr = 2'b00;
  logic [1:0]  cpu_ltype = 2'b00;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  mem_access_unit #(.ADDR_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_ifetch(cpu_ifetch),
    .cpu_memwr(cpu_memwr), .cpu_ltype(cpu_ltype), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .stall(stall), .instr(instr), .rdata(rdata),
    .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [31:0] instr;
    logic [31:0] rdata;
    int          cycles;
    int          reqs;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int   checks = 0;
  int   errors = 0;

  int          ack_wait = -1;
  logic [31:0] resp_rdata = 32'h0;
  bit          force_ack = 1'b0;
  int          resp_cnt = 0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_rdata = 32'h0;

  function automatic void chk(input string nm, input logic [95:0] act, input logic [95:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endfunction

  // Bus responder: acks on the (ack_wait+1)-th cycle of mem_req; negative never acks.
  always @(negedge clk) begin
    mem_rdata = resp_rdata;
    if (reset && mem_req) begin
      resp_cnt++;
      mem_ack = (ack_wait >= 0) && (resp_cnt == ack_wait + 1);
    end else begin
      resp_cnt = 0;
      mem_ack  = force_ack;
    end
  end

  // Monitor: checks bus fields on request start and hold, and each completion.
  bit   prev_stall = 1'b0;
  bit   prev_req = 1'b0;
  int   st_cycles = 0;
  int   req_cycles = 0;
  bus_t cur_bus;
  exp_t cur_exp;

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
      prev_req   = 1'b0;
      st_cycles  = 0;
      req_cycles = 0;
    end else begin
      if (mem_req) begin
        if (!prev_req) begin
          if (bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got mem_req=1 at addr %0h expected no bus cycle", mem_addr);
            cur_bus = '{addr: mem_addr, be: mem_be, we: mem_we, wdata: mem_wdata};
          end else begin
            cur_bus = bus_q.pop_front();
            chk("bus_addr", 96'(mem_addr), 96'(cur_bus.addr));
            chk("bus_be", 96'(mem_be), 96'(cur_bus.be));
            chk("bus_we", 96'(mem_we), 96'(cur_bus.we));
            chk("bus_wdata", 96'(mem_wdata), 96'(cur_bus.wdata));
          end
        end else begin
          chk("bus_hold", 96'({mem_addr, mem_be, mem_we, mem_wdata}),
              96'({cur_bus.addr, cur_bus.be, cur_bus.we, cur_bus.wdata}));
        end
        req_cycles++;
      end
      prev_req = mem_req;
      if (err && !(prev_stall && !stall)) begin
        checks++;
        errors++;
        $display("FAIL err_outside_done: got err=1 expected 0");
      end
      if (stall) begin
        st_cycles++;
      end else if (prev_stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got completion expected none");
        end else begin
          cur_exp = exp_q.pop_front();
          chk("done_err", 96'(err), 96'(cur_exp.err));
          chk("done_instr", 96'(instr), 96'(cur_exp.instr));
          chk("done_rdata", 96'(rdata), 96'(cur_exp.rdata));
          chk("done_cycles", 96'(st_cycles + 1), 96'(cur_exp.cycles));
          chk("done_reqs", 96'(req_cycles), 96'(cur_exp.reqs));
        end
        st_cycles  = 0;
        req_cycles = 0;
      end
      prev_stall = stall;
    end
  end

  // One CPU access; waitst<0 means the bus never acks (timeout expected).
  task automatic issue(input bit ifetch, input logic [1:0] memwr, input logic [1:0] ltype,
                       input logic [31:0] addr, input logic [31:0] wdata, input int waitst,
                       input logic [31:0] brd, input bit exp_err, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input logic [31:0] exp_ins,
                       input logic [31:0] exp_rd);
    exp_t e;
    bus_t b;
    bit   done;
    e.err   = exp_err;
    e.instr = exp_ins;
    e.rdata = exp_rd;
    if (waitst < 0) begin
      e.cycles = MAX_WAIT + 2;
      e.reqs   = MAX_WAIT;
    end else if (exp_err) begin
      e.cycles = 2;
      e.reqs   = 0;
    end else begin
      e.cycles = 3 + waitst;
      e.reqs   = waitst + 1;
    end
    if (!(exp_err && waitst >= 0)) begin
      b.addr  = addr & 32'hFFFF_FFFC;
      b.be    = exp_be;
      b.we    = (memwr != 2'b00);
      b.wdata = exp_wd;
      bus_q.push_back(b);
    end
    exp_q.push_back(e);
    m_instr = exp_ins;
    m_rdata = exp_rd;
    @(posedge clk);
    #1;
    cpu_ifetch = ifetch;
    cpu_memwr  = memwr;
    cpu_ltype  = ltype;
    cpu_addr   = addr;
    cpu_wdata  = wdata;
    ack_wait   = waitst;
    resp_rdata = brd;
    cpu_req    = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_bound: got stall held 40 cycles expected release at addr %0h", addr);
    end
    @(posedge clk);
    #1;
    cpu_req    = 1'b0;
    cpu_ifetch = 1'b0;
    cpu_memwr  = 2'b00;
    cpu_ltype  = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_mem_req", 96'(mem_req), 96'(0));
    chk("rst_mem_we", 96'(mem_we), 96'(0));
    chk("rst_mem_be", 96'(mem_be), 96'(0));
    chk("rst_mem_addr", 96'(mem_addr), 96'(0));
    chk("rst_mem_wdata", 96'(mem_wdata), 96'(0));
    chk("rst_instr", 96'(instr), 96'(0));
    chk("rst_rdata", 96'(rdata), 96'(0));
    chk("rst_err", 96'(err), 96'(0));
    chk("rst_stall", 96'(stall), 96'(0));
    @(negedge clk);
    reset = 1'b1;

    // fetch, ack on first request cycle
    issue(1, 2'b00, 2'b00, 32'h40, 32'h0, 0, 32'h8C010004, 0, 4'hF, 32'h0, 32'h8C010004, m_rdata);
    // byte loads with wait states, sign and zero extension
    issue(0, 2'b00, 2'b10, 32'h103, 32'h0, 2, 32'h80FF0000, 0, 4'hF, 32'h0, m_instr, 32'hFFFFFF80);
    issue(0, 2'b00, 2'b01, 32'h103, 32'h0, 2, 32'h80FF0000, 0, 4'hF, 32'h0, m_instr, 32'h00000080);
    issue(0, 2'b00, 2'b10, 32'h101, 32'h0, 0, 32'h00007F00, 0, 4'hF, 32'h0, m_instr, 32'h0000007F);
    issue(0, 2'b00, 2'b00, 32'h108, 32'h0, 1, 32'h11223344, 0, 4'hF, 32'h0, m_instr, 32'h11223344);
    // stores
    issue(0, 2'b10, 2'b00, 32'h102, 32'h123456AB, 1, 32'h0, 0, 4'b0100, 32'hABABABAB, m_instr, m_rdata);
    issue(0, 2'b01, 2'b11, 32'h104, 32'hDEADBEEF, 0, 32'h0, 0, 4'hF, 32'hDEADBEEF, m_instr, m_rdata);
    // misaligned and illegal encodings: no bus cycle, err in DONE
    issue(0, 2'b01, 2'b00, 32'h101, 32'h55, 0, 32'h0, 1, 4'h0, 32'h0, m_instr, m_rdata);
    issue(0, 2'b11, 2'b00, 32'h100, 32'h0, 0, 32'h0, 1, 4'h0, 32'h0, m_instr, m_rdata);
    issue(0, 2'b00, 2'b11, 32'h100, 32'h0, 0, 32'h0, 1, 4'h0, 32'h0, m_instr, m_rdata);
    issue(1, 2'b01, 2'b00, 32'h100, 32'h0, 0, 32'h0, 1, 4'h0, 32'h0, m_instr, m_rdata);
    issue(1, 2'b00, 2'b00, 32'h42, 32'h0, 0, 32'h0, 1, 4'h0, 32'h0, m_instr, m_rdata);
    issue(0, 2'b00, 2'b00, 32'h102, 32'h0, 0, 32'h0, 1, 4'h0, 32'h0, m_instr, m_rdata);
    // timeout, then a late ack with no request outstanding
    issue(0, 2'b00, 2'b00, 32'h200, 32'h0, -1, 32'hCAFEF00D, 1, 4'hF, 32'h0, m_instr, m_rdata);
    @(posedge clk);
    #1;
    resp_rdata = 32'hFFFF0000;
    force_ack  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    force_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_stall", 96'(stall), 96'(0));
    chk("late_ack_req", 96'(mem_req), 96'(0));
    chk("late_ack_instr", 96'(instr), 96'(m_instr));
    chk("late_ack_rdata", 96'(rdata), 96'(m_rdata));

    // reset in the middle of a WAIT
    @(posedge clk);
    #1;
    bus_q.push_back('{addr: 32'h300, be: 4'hF, we: 1'b0, wdata: 32'h0});
    cpu_addr  = 32'h300;
    cpu_memwr = 2'b00;
    cpu_ltype = 2'b00;
    ack_wait  = -1;
    cpu_req   = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    reset   = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("midrst_req", 96'(mem_req), 96'(0));
    chk("midrst_stall", 96'(stall), 96'(0));
    chk("midrst_instr", 96'(instr), 96'(0));
    chk("midrst_rdata", 96'(rdata), 96'(0));
    chk("midrst_be", 96'(mem_be), 96'(0));
    m_instr = 32'h0;
    m_rdata = 32'h0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    issue(1, 2'b00, 2'b00, 32'h44, 32'h0, 0, 32'h01234567, 0, 4'hF, 32'h0, 32'h01234567, m_rdata);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || bus_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got %0d completions %0d bus cycles pending expected 0 0",
               exp_q.size(), bus_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
